// File: rtl/fft_transpose_buffer.sv
// Two-bank ping-pong buffer that transposes 4x4 lane frames between the two
// radix-4 passes of the 16-point FFT.
module fft_transpose_buffer (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [135:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [135:0] out_data,
    output logic [2:0]   out_rot,
    output logic         out_last
);

    localparam int LANE_W = 34;
    localparam int WORD_W = 4 * LANE_W;

    logic [WORD_W-1:0] bank_r [2][4];
    logic [1:0]        full_r;
    logic              wr_sel_r;
    logic              rd_sel_r;
    logic [1:0]        wr_cnt_r;
    logic [1:0]        rd_cnt_r;

    logic              accept_s;
    logic              xfer_s;
    logic [1:0]        full_set_s;
    logic [1:0]        full_clr_s;
    logic [1:0]        full_next_s;

    function automatic logic [LANE_W-1:0] lane_of(input logic [WORD_W-1:0] word,
                                                  input logic [1:0] idx);
        logic [LANE_W-1:0] lane;
        case (idx)
            2'd0:    lane = word[33:0];
            2'd1:    lane = word[67:34];
            2'd2:    lane = word[101:68];
            2'd3:    lane = word[135:102];
            default: lane = {LANE_W{1'b0}};
        endcase
        return lane;
    endfunction

    assign in_ready  = ~full_r[wr_sel_r];
    assign out_valid = full_r[rd_sel_r];
    assign accept_s  = in_valid & in_ready;
    assign xfer_s    = out_valid & out_ready;
    assign out_rot   = {1'b1, rd_cnt_r};
    assign out_last  = out_valid & (rd_cnt_r == 2'd3);

    // Frame completion sets a bank's flag; draining its last word clears it.
    assign full_set_s = (accept_s && (wr_cnt_r == 2'd3)) ? (2'b01 << wr_sel_r) : 2'b00;
    assign full_clr_s = (xfer_s && (rd_cnt_r == 2'd3)) ? (2'b01 << rd_sel_r) : 2'b00;
    assign full_next_s = (full_r | full_set_s) & ~full_clr_s;

    // Column gather: output lane j is lane rd_cnt of stored word j.
    always_comb begin
        out_data = {WORD_W{1'b0}};
        for (int j = 0; j < 4; j++) begin
            out_data[j*LANE_W +: LANE_W] = lane_of(bank_r[rd_sel_r][j], rd_cnt_r);
        end
    end

    // Bank storage plus write and read pointer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < 4; w++) begin
                    bank_r[b][w] <= {WORD_W{1'b0}};
                end
            end
            full_r   <= 2'b00;
            wr_sel_r <= 1'b0;
            rd_sel_r <= 1'b0;
            wr_cnt_r <= 2'd0;
            rd_cnt_r <= 2'd0;
        end else begin
            if (accept_s) begin
                bank_r[wr_sel_r][wr_cnt_r] <= in_data;
                wr_cnt_r <= wr_cnt_r + 2'd1;
                if (wr_cnt_r == 2'd3) begin
                    wr_sel_r <= ~wr_sel_r;
                end
            end
            if (xfer_s) begin
                rd_cnt_r <= rd_cnt_r + 2'd1;
                if (rd_cnt_r == 2'd3) begin
                    rd_sel_r <= ~rd_sel_r;
                end
            end
            full_r <= full_next_s;
        end
    end

endmodule

// File: tb/tb_fft_transpose_buffer.sv
// Randomized bench for fft_transpose_buffer, compared against a frame-level
// queue model of the transpose.
module tb_fft_transpose_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [135:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [135:0] out_data;
    logic [2:0]   out_rot;
    logic         out_last;

    int tests_run = 0;
    int tests_failed = 0;

    logic [135:0] src_q[$];
    logic [135:0] exp_data_q[$];
    logic [2:0]   exp_rot_q[$];
    logic         exp_last_q[$];
    logic [135:0] part[4];
    int           part_n = 0;
    int           frames_held = 0;

    always #5 clk = ~clk;

    fft_transpose_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rot   (out_rot),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] lane(input logic [135:0] w, input int i);
        return w[34*i +: 34];
    endfunction

    // Word j of the test pattern: lane i has Re = 4j+i+offset, Im = 0.
    function automatic logic [135:0] pattern_word(input int j, input int offset);
        logic [135:0] w;
        logic [16:0]  re;
        w = 136'd0;
        for (int i = 0; i < 4; i++) begin
            re = 17'(4*j + i + offset);
            w[34*i +: 34] = {re, 17'd0};
        end
        return w;
    endfunction

    function automatic logic [135:0] rand_word();
        return 136'({$urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    // Output word k of a frame collects lane k from each of the four input words.
    task automatic model_frame_done();
        logic [135:0] w;
        for (int k = 0; k < 4; k++) begin
            w = 136'd0;
            for (int j = 0; j < 4; j++) begin
                w[34*j +: 34] = lane(part[j], k);
            end
            exp_data_q.push_back(w);
            exp_rot_q.push_back(3'(4 + k));
            exp_last_q.push_back(k == 3);
        end
        frames_held++;
    endtask

    task automatic model_reset();
        src_q.delete();
        exp_data_q.delete();
        exp_rot_q.delete();
        exp_last_q.delete();
        part_n = 0;
        frames_held = 0;
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model at posedge.
    // rprob < 0 toggles out_ready every cycle.
    task automatic cycle(input int vprob, input int rprob);
        logic acc;
        logic xfer;
        if (rprob < 0) out_ready = ~out_ready;
        else           out_ready = ($urandom_range(99) < rprob);
        in_valid = (src_q.size() != 0) && ($urandom_range(99) < vprob);
        in_data  = in_valid ? src_q[0] : rand_word();
        @(negedge clk);
        check("in_ready", 136'(in_ready), 136'(frames_held < 2));
        check("out_valid", 136'(out_valid), 136'(exp_data_q.size() != 0));
        if (exp_data_q.size() != 0) begin
            check("out_data", out_data, exp_data_q[0]);
            check("out_rot", 136'(out_rot), 136'(exp_rot_q[0]));
            check("out_last", 136'(out_last), 136'(exp_last_q[0]));
        end else begin
            check("out_last_idle", 136'(out_last), 136'(1'b0));
        end
        acc  = in_valid && (frames_held < 2);
        xfer = out_ready && (exp_data_q.size() != 0);
        @(posedge clk);
        if (xfer) begin
            if (exp_last_q[0]) frames_held--;
            void'(exp_data_q.pop_front());
            void'(exp_rot_q.pop_front());
            void'(exp_last_q.pop_front());
        end
        if (acc) begin
            part[part_n] = src_q.pop_front();
            part_n++;
            if (part_n == 4) begin
                model_frame_done();
                part_n = 0;
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = 136'd0;
        model_reset();
        #2;
        check("rst_in_ready", 136'(in_ready), 136'(1'b1));
        check("rst_out_valid", 136'(out_valid), 136'(1'b0));
        check("rst_out_last", 136'(out_last), 136'(1'b0));
        check("rst_out_data", out_data, 136'd0);
        check("rst_out_rot", 136'(out_rot), 136'(3'b100));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single frame
        for (int j = 0; j < 4; j++) src_q.push_back(pattern_word(j, 0));
        repeat (8) cycle(100, 100);

        // Three back-to-back frames at full rate
        for (int f = 0; f < 3; f++)
            for (int j = 0; j < 4; j++) src_q.push_back(pattern_word(j, 16*f));
        repeat (18) cycle(100, 100);

        // Backpressure: two frames fill both banks, ninth word must wait
        for (int j = 0; j < 9; j++) src_q.push_back(pattern_word(j, 64));
        repeat (12) cycle(100, 0);
        for (int j = 9; j < 12; j++) src_q.push_back(pattern_word(j, 64));
        repeat (16) cycle(100, 100);

        // Stall every other cycle on the read side
        for (int j = 0; j < 8; j++) src_q.push_back(rand_word());
        repeat (30) cycle(100, -1);
        repeat (10) cycle(0, 100);

        // Async reset with a half-written frame
        for (int j = 0; j < 2; j++) src_q.push_back(rand_word());
        repeat (3) cycle(100, 100);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 136'(out_valid), 136'(1'b0));
        check("mid_rst_in_ready", 136'(in_ready), 136'(1'b1));
        check("mid_rst_out_data", out_data, 136'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) src_q.push_back(pattern_word(j, 200));
        repeat (8) cycle(100, 100);

        // Random traffic
        for (int j = 0; j < 160; j++) src_q.push_back(rand_word());
        repeat (400) cycle(70, 60);
        repeat (12) cycle(0, 100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
